// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between core (C) and DMA (D)
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic [DW-1:0] rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, GNT_C, GNT_D} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_last_d;   // 1 = DMA was granted most recently
   logic          w_cnt_max;

   assign w_cnt_max = (r_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_last_d <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (!w_cnt_max)
            r_cnt <= r_cnt + CW'(1);
         if (w_next == GNT_C && r_state != GNT_C)
            r_last_d <= 1'b0;
         else if (w_next == GNT_D && r_state != GNT_D)
            r_last_d <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (c_req && d_req)
               w_next = r_last_d ? GNT_C : GNT_D;
            else if (c_req)
               w_next = GNT_C;
            else if (d_req)
               w_next = GNT_D;
         end
         GNT_C: begin
            if (!c_req)
               w_next = d_req ? GNT_D : IDLE;
            else if (d_req && w_cnt_max)
               w_next = GNT_D;
         end
         GNT_D: begin
            if (!d_req)
               w_next = c_req ? GNT_C : IDLE;
            else if (c_req && w_cnt_max)
               w_next = GNT_C;
         end
         default: w_next = IDLE;
      endcase
   end

   assign c_gnt   = (r_state == GNT_C);
   assign d_gnt   = (r_state == GNT_D);
   assign c_stall = c_req & ~c_gnt;
   assign rdata   = mem_rdata;

   // Write enable is gated by reset so a mid-burst reset suppresses the write immediately
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         GNT_C: begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we & c_req & reset;
         end
         GNT_D: begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we & d_req & reset;
         end
         default: ;
      endcase
   end

endmodule
